rx_frame_parser: RTL and testbench
==================================

Name: rx_frame_parser

Overview:
Parametrised successor to the first-generation receive MAC control. It sits in the switch_clk domain after the receive CDC FIFO. It consumes a byte stream that carries an explicit end-of-frame marker and a PHY error flag, and checks the preamble/SFD. It then extracts header fields, verifies FCS by residue, enforces min/max frame length, optionally strips FCS, and drives a valid/ready stream to learning/lookup and memory with full backpressure and saturating statistics.

Parameters:
PREAMBLE_LEN, 7, maximum number of 0x55 bytes allowed before the SFD (0xD5); at least 1 is required.
MIN_FRAME_LEN, 64, minimum length in bytes, DA through FCS inclusive.
MAX_FRAME_LEN, 1518, maximum length in bytes, DA through FCS inclusive.
STRIP_FCS, 1, 1 = FCS not forwarded (4-byte delay line); 0 = all bytes forwarded.
CNT_WIDTH, 32, width of each statistics counter.

Ports:
switch_clk  in  1  clock
switch_rst_n  in  1  reset, asynchronous, active-low
in_data  in  8  byte from CDC FIFO
in_valid  in  1  in_data valid
in_last  in  1  byte is the final byte of the GMII burst
in_err  in  1  gmii_rx_er was seen on this byte
in_ready  out  1  byte accepted when in_valid && in_ready
out_data  out  8  forwarded frame byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts
out_sof  out  1  qualifies the first forwarded byte (DA[0])
out_eof  out  1  qualifies the last forwarded byte
out_err_code  out  3  valid with out_eof: [0] CRC, [1] length, [2] PHY error
mac_dst_addr_o  out  48  destination MAC, first byte in [47:40]
mac_src_addr_o  out  48  source MAC, first byte in [47:40]
ethertype_o  out  16  type/length field
hdr_valid_o  out  1  1-cycle pulse; the three fields are stable until the next pulse
stat_frames_ok, stat_frames_err, stat_crc_err, stat_len_err, stat_preamble_err  out  CNT_WIDTH each  saturating counters

Behaviour:
- Reset: every output is 0, state is IDLE, and the delay line, CRC and length counter are cleared. A mid-frame reset discards the frame with no eof emitted and no counter change.
- States:
  - IDLE: 0x55 goes to PRE with pre_cnt=1; any other byte is discarded and the state stays IDLE.
  - PRE: 0x55 with pre_cnt<PREAMBLE_LEN increments pre_cnt. 0xD5 goes to BODY, with CRC=0xFFFFFFFF and len=0. Any other byte, or 0x55 beyond PREAMBLE_LEN, goes to DROP and increments stat_preamble_err.
  - BODY: forwarding and checking.
  - DROP: consume bytes until in_last is accepted, then go to IDLE.
- in_last behaviour outside BODY:
  - in_last accepted in PRE goes to IDLE and increments stat_preamble_err.
  - If in_last is on the byte that triggers DROP, the next state is IDLE, not DROP.
- in_ready: 1 in IDLE, PRE and DROP. In BODY it is !out_valid || out_ready (single output register, no combinational in_valid-to-out_valid path).
- Output handshake: while out_valid && !out_ready, all out_* signals hold stable.
- CRC:
  - Reflected poly 0xEDB88320, updated on each BODY byte including the FCS bytes.
  - At in_last the frame passes when CRC == 32'hDEBB20E3; otherwise err[0] is set.
- Length:
  - len counts BODY bytes.
  - At in_last, len<MIN_FRAME_LEN sets err[1].
  - Accepting byte number MAX_FRAME_LEN+1 without in_last also sets err[1] (giant). The eof goes on the byte emitted in that cycle, and the state moves to DROP.
  - len==MAX_FRAME_LEN at in_last is legal.
- PHY error: in_err on any PRE or BODY byte sets sticky err[2] for the frame.
- STRIP_FCS=1:
  - Accepted bytes enter a 4-byte delay line. A byte is emitted only when a 5th byte is accepted behind it.
  - When in_last is accepted, the emitted byte carries out_eof and the final out_err_code, and the 4 held FCS bytes are flushed.
  - If in_last arrives with len<=4, nothing has been emitted; the frame is silently dropped except for the counters.
- STRIP_FCS=0: a byte accepted in cycle N gives out_valid in N+1. The in_last byte carries out_eof.
- out_sof is set on the first emitted byte of the frame. If that byte is also eof, both are set.
- Header:
  - DA is shifted in from BODY bytes 1-6, SA from bytes 7-12 and type from bytes 13-14.
  - hdr_valid_o pulses the cycle after byte 14 is accepted.
  - There is no pulse if the frame ends or is dropped first.
- Counters, each saturating at all-ones:
  - At frame end, err==0 increments stat_frames_ok; otherwise stat_frames_err increments.
  - stat_crc_err and stat_len_err increment once per frame when their bit is set.
  - Giant frames are counted at the giant event.

Test Plan:
- STRIP_FCS=1, preamble 7×0x55 + 0xD5, 64-byte good frame with DA 01:02:03:04:05:06 and SA 0A:0B:0C:0D:0E:0F -> 60 bytes out, sof on byte 1, eof on byte 60, err_code 3'b000; hdr_valid_o pulses once with the matching DA/SA; stat_frames_ok=1.
- Same frame with last FCS byte XOR 0x01 -> 60 bytes out, eof with err_code 3'b001; stat_crc_err=1, stat_frames_err=1.
- Good frame with out_ready toggling 1-cycle on / 2-cycle off -> byte sequence identical to the ready=1 case, and in_ready low whenever out_valid && !out_ready.
- 7×0x55 + 0x5D, then in_last, then a good frame -> no output for the first burst, stat_preamble_err=1; the second frame is forwarded intact.
- 1600-byte body, MAX_FRAME_LEN=1518 -> eof on output byte 1515 with err_code 3'b010; remaining input is consumed with no output; stat_len_err=1; the next frame passes.
- Two configuration cases:
  - 40-byte frame with valid CRC, STRIP_FCS=0 -> 40 bytes out, eof with 3'b010.
  - Reset asserted at body byte 20 -> all outputs 0 immediately, counters unchanged, and the next frame passes.

Source files
------------

// File: rtl/rx_frame_parser.sv
// rx_frame_parser: receive framing after the CDC FIFO; preamble/SFD check, header extraction,
// FCS residue and length checks, optional FCS strip, valid/ready output and saturating stats.
module rx_frame_parser #(
  parameter int PREAMBLE_LEN  = 7,
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter bit STRIP_FCS     = 1'b1,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 switch_clk,
  input  logic                 switch_rst_n,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 in_err,
  output logic                 in_ready,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic [2:0]           out_err_code,
  output logic [47:0]          mac_dst_addr_o,
  output logic [47:0]          mac_src_addr_o,
  output logic [15:0]          ethertype_o,
  output logic                 hdr_valid_o,
  output logic [CNT_WIDTH-1:0] stat_frames_ok,
  output logic [CNT_WIDTH-1:0] stat_frames_err,
  output logic [CNT_WIDTH-1:0] stat_crc_err,
  output logic [CNT_WIDTH-1:0] stat_len_err,
  output logic [CNT_WIDTH-1:0] stat_preamble_err
);
  localparam logic [1:0] IDLE = 2'd0, PRE = 2'd1, BODY = 2'd2, DROP = 2'd3;
  localparam int LW = $clog2(MAX_FRAME_LEN + 2);
  localparam int PW = $clog2(PREAMBLE_LEN + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PREAMBLE_LEN);
  localparam logic [LW-1:0] LEN_MIN = LW'(MIN_FRAME_LEN);
  localparam logic [LW-1:0] LEN_GIANT = LW'(MAX_FRAME_LEN + 1);

  logic [1:0] state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [31:0] crc_q, crc_n, dl_q;
  logic [LW-1:0] len_q, len_n;
  logic [103:0] hdr_q;
  logic [111:0] hdr_full;
  logic [2:0] err_n;
  logic phy_q, sof_pend_q, acc, body_acc, fin, giant, end_ev, emit, pre_err_ev;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat(input logic [CNT_WIDTH-1:0] c, input logic en);
    return (en && !(&c)) ? c + 1'b1 : c;
  endfunction

  assign in_ready = (state_q != BODY) || !out_valid || out_ready;
  assign acc = in_valid && in_ready;
  assign body_acc = acc && state_q == BODY;
  assign crc_n = crc_byte(crc_q, in_data);
  assign len_n = len_q + 1'b1;
  assign fin = body_acc && in_last;
  assign giant = body_acc && !in_last && len_n == LEN_GIANT;
  assign end_ev = fin || giant;
  assign err_n = {phy_q | in_err, (fin && len_n < LEN_MIN) || giant, fin && crc_n != 32'hDEBB20E3};
  // With stripping, a byte only leaves once four newer bytes sit behind it.
  assign emit = body_acc && (!STRIP_FCS || len_q >= LW'(4));
  assign hdr_full = {hdr_q, in_data};
  assign pre_err_ev = acc && state_q == PRE && state_d != BODY && state_d != PRE;

  always_comb begin
    state_d = state_q;
    pre_d = pre_q;
    if (acc)
      case (state_q)
        IDLE: if (in_data == 8'h55) begin
          state_d = PRE;
          pre_d = PW'(1);
        end
        PRE: if (in_last) state_d = IDLE;
          else if (in_data == 8'hD5) state_d = BODY;
          else if (in_data == 8'h55 && pre_q < PRE_MAX) pre_d = pre_q + 1'b1;
          else state_d = DROP;
        BODY: state_d = in_last ? IDLE : giant ? DROP : BODY;
        default: state_d = in_last ? IDLE : DROP;
      endcase
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n)
    if (!switch_rst_n) begin
      state_q <= IDLE;
      pre_q <= '0;
      crc_q <= '0;
      dl_q <= '0;
      len_q <= '0;
      hdr_q <= '0;
      phy_q <= 1'b0;
      sof_pend_q <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_sof <= 1'b0;
      out_eof <= 1'b0;
      out_err_code <= '0;
      mac_dst_addr_o <= '0;
      mac_src_addr_o <= '0;
      ethertype_o <= '0;
      hdr_valid_o <= 1'b0;
      stat_frames_ok <= '0;
      stat_frames_err <= '0;
      stat_crc_err <= '0;
      stat_len_err <= '0;
      stat_preamble_err <= '0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      if (acc) phy_q <= (state_q == IDLE ? 1'b0 : phy_q) | in_err;
      if (acc && state_q == PRE && state_d == BODY) begin
        crc_q <= '1;
        len_q <= '0;
        dl_q <= '0;
        sof_pend_q <= 1'b1;
      end
      if (body_acc) begin
        crc_q <= crc_n;
        len_q <= len_n;
        dl_q <= {dl_q[23:0], in_data};
        if (len_q < LW'(14)) hdr_q <= hdr_full[103:0];
      end
      hdr_valid_o <= body_acc && !in_last && len_n == LW'(14);
      if (body_acc && !in_last && len_n == LW'(14)) begin
        mac_dst_addr_o <= hdr_full[111:64];
        mac_src_addr_o <= hdr_full[63:16];
        ethertype_o <= hdr_full[15:0];
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_data <= STRIP_FCS ? dl_q[31:24] : in_data;
        out_sof <= sof_pend_q;
        out_eof <= end_ev;
        out_err_code <= end_ev ? err_n : 3'b000;
        sof_pend_q <= 1'b0;
      end else if (out_ready) out_valid <= 1'b0;
      stat_frames_ok <= sat(stat_frames_ok, end_ev && err_n == 3'b000);
      stat_frames_err <= sat(stat_frames_err, end_ev && err_n != 3'b000);
      stat_crc_err <= sat(stat_crc_err, end_ev && err_n[0]);
      stat_len_err <= sat(stat_len_err, end_ev && err_n[1]);
      stat_preamble_err <= sat(stat_preamble_err, pre_err_ev);
    end
endmodule

// File: tb/tb_rx_frame_parser.sv
// tb_rx_frame_parser: table-driven frames plus hand sequences, scoreboarded against expected beats.
module tb_rx_frame_parser;
  typedef struct packed {logic [7:0] d; logic sof; logic eof; logic [2:0] err;} beat_t;
  typedef struct {int len; logic bad; int phy_at; logic rmode; logic [2:0] err;} vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n, sel, in_valid, in_last, in_err, out_ready, rmode, in_body;
  logic [7:0] in_data;
  logic va, vb, rdy_a, rdy_b, ov_a, ov_b, sof_a, sof_b, eof_a, eof_b, hv_a, hv_b;
  logic [7:0] od_a, od_b;
  logic [2:0] ec_a, ec_b;
  logic [47:0] da_a, sa_a, da_b, sa_b;
  logic [15:0] et_a, et_b;
  logic [31:0] ok_a, fe_a, ce_a, le_a, pe_a, ok_b, fe_b, ce_b, le_b, pe_b;
  beat_t qa[$], qb[$];
  logic [111:0] ha[$], hb[$];
  logic [7:0] body[$];
  int checks = 0, fails = 0, cyc = 0;
  int e_ok = 0, e_fe = 0, e_ce = 0, e_le = 0, e_pe = 0;

  assign va = in_valid && !sel;
  assign vb = in_valid && sel;

  rx_frame_parser dut_a (
    .switch_clk(clk), .switch_rst_n(rst_a_n), .in_data(in_data), .in_valid(va), .in_last(in_last),
    .in_err(in_err), .in_ready(rdy_a), .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready),
    .out_sof(sof_a), .out_eof(eof_a), .out_err_code(ec_a), .mac_dst_addr_o(da_a), .mac_src_addr_o(sa_a),
    .ethertype_o(et_a), .hdr_valid_o(hv_a), .stat_frames_ok(ok_a), .stat_frames_err(fe_a),
    .stat_crc_err(ce_a), .stat_len_err(le_a), .stat_preamble_err(pe_a));

  rx_frame_parser #(.STRIP_FCS(1'b0)) dut_b (
    .switch_clk(clk), .switch_rst_n(rst_b_n), .in_data(in_data), .in_valid(vb), .in_last(in_last),
    .in_err(in_err), .in_ready(rdy_b), .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready),
    .out_sof(sof_b), .out_eof(eof_b), .out_err_code(ec_b), .mac_dst_addr_o(da_b), .mac_src_addr_o(sa_b),
    .ethertype_o(et_b), .hdr_valid_o(hv_b), .stat_frames_ok(ok_b), .stat_frames_err(fe_b),
    .stat_crc_err(ce_b), .stat_len_err(le_b), .stat_preamble_err(pe_b));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rmode ? (cyc % 3 == 0) : 1'b1;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (ov_a && out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_beat", {od_a, sof_a, eof_a, ec_a}, 128'h1ffff);
      else chk("a_beat", {od_a, sof_a, eof_a, ec_a}, qa.pop_front());
    end
    if (ov_b && out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_beat", {od_b, sof_b, eof_b, ec_b}, 128'h1ffff);
      else chk("b_beat", {od_b, sof_b, eof_b, ec_b}, qb.pop_front());
    end
    if (hv_a) begin
      if (ha.size() == 0) chk("a_unexpected_hdr", {da_a, sa_a, et_a}, '1);
      else chk("a_hdr", {da_a, sa_a, et_a}, ha.pop_front());
    end
    if (hv_b) begin
      if (hb.size() == 0) chk("b_unexpected_hdr", {da_b, sa_b, et_b}, '1);
      else chk("b_hdr", {da_b, sa_b, et_b}, hb.pop_front());
    end
    if (in_body && !sel && ov_a && !out_ready) chk("a_in_ready_backpressure", rdy_a, 0);
  end

  task automatic build(input int len, input logic bad, input int seed);
    logic [31:0] c;
    body = {};
    for (int i = 0; i < len - 4; i++)
      body.push_back(i < 6 ? 8'(i + 1) : i < 12 ? 8'(i + 4) : i == 12 ? 8'h08 : i == 13 ? 8'h00 : 8'(i * 7 + seed));
    c = '1;
    foreach (body[i]) c = crc_byte(c, body[i]);
    c = ~c;
    for (int k = 0; k < 4; k++) body.push_back(c[8*k +: 8]);
    if (bad) body[len-1] = body[len-1] ^ 8'h01;
  endtask

  task automatic expect_frame(input int n_out, input logic eof_end, input logic [2:0] err, input int n_in);
    beat_t e;
    logic [111:0] h;
    for (int i = 0; i < n_out; i++) begin
      e.d = body[i];
      e.sof = (i == 0);
      e.eof = eof_end && i == n_out - 1;
      e.err = e.eof ? err : 3'b000;
      if (sel) qb.push_back(e); else qa.push_back(e);
    end
    if (n_in >= 15) begin
      h = '0;
      for (int k = 0; k < 14; k++) h = {h[103:0], body[k]};
      if (sel) hb.push_back(h); else ha.push_back(h);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic e);
    int t;
    logic took;
    t = 0;
    in_data = d;
    in_last = l;
    in_err = e;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      took = sel ? rdy_b : rdy_a;
      @(posedge clk);
      #1;
      t++;
    end while (!took && t < 200);
    if (!took) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: byte %0h not accepted, expected acceptance within 200 cycles", d);
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    in_err = 1'b0;
  endtask

  task automatic send_pre();
    repeat (7) send(8'h55, 1'b0, 1'b0);
    send(8'hD5, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input int phy_at);
    send_pre();
    in_body = 1'b1;
    foreach (body[i]) send(body[i], i == body.size() - 1, i + 1 == phy_at);
    in_body = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((qa.size() + qb.size() + ha.size() + hb.size()) != 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("drain_pending", qa.size() + qb.size() + ha.size() + hb.size(), 0);
  endtask

  task automatic stats_a();
    chk("a_frames_ok", ok_a, e_ok);
    chk("a_frames_err", fe_a, e_fe);
    chk("a_crc_err", ce_a, e_ce);
    chk("a_len_err", le_a, e_le);
    chk("a_preamble_err", pe_a, e_pe);
  endtask

  task automatic good_a(input int seed);
    build(64, 1'b0, seed);
    expect_frame(60, 1'b1, 3'b000, 64);
    send_frame(0);
    drain();
    e_ok++;
    stats_a();
  endtask

  initial begin
    vec_t tv[7];
    int n;
    tv[0] = '{64, 1'b0, 0, 1'b0, 3'b000};
    tv[1] = '{64, 1'b1, 0, 1'b0, 3'b001};
    tv[2] = '{64, 1'b0, 0, 1'b1, 3'b000};
    tv[3] = '{63, 1'b0, 0, 1'b0, 3'b010};
    tv[4] = '{1518, 1'b0, 0, 1'b0, 3'b000};
    tv[5] = '{64, 1'b0, 30, 1'b1, 3'b100};
    tv[6] = '{4, 1'b0, 0, 1'b0, 3'b010};
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    sel = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_err = 1'b0;
    in_data = 8'h00;
    rmode = 1'b0;
    in_body = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("a_reset_out", {od_a, ov_a, sof_a, eof_a, ec_a, hv_a}, 0);
    chk("a_reset_hdr", {da_a, sa_a, et_a}, 0);
    stats_a();
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      rmode = tv[i].rmode;
      build(tv[i].len, tv[i].bad, i);
      n = tv[i].len > 4 ? tv[i].len - 4 : 0;
      expect_frame(n, 1'b1, tv[i].err, tv[i].len);
      send_frame(tv[i].phy_at);
      drain();
      rmode = 1'b0;
      if (tv[i].err == 3'b000) e_ok++; else e_fe++;
      if (tv[i].err[0]) e_ce++;
      if (tv[i].err[1]) e_le++;
      stats_a();
    end

    // bad SFD, then a burst end while dropping
    repeat (7) send(8'h55, 1'b0, 1'b0);
    send(8'h5D, 1'b0, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    e_pe++;
    good_a(11);
    // too many preamble bytes; in_last on the SFD byte while dropping
    repeat (8) send(8'h55, 1'b0, 1'b0);
    send(8'hD5, 1'b1, 1'b0);
    e_pe++;
    // burst ends inside the preamble
    send(8'h55, 1'b0, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    e_pe++;
    good_a(12);

    // giant: eof on output byte 1515, rest swallowed
    build(1600, 1'b0, 13);
    expect_frame(1515, 1'b1, 3'b010, 1600);
    send_frame(0);
    drain();
    e_fe++;
    e_le++;
    stats_a();
    good_a(14);

    // unstripped instance: reset in the middle of a frame
    sel = 1'b1;
    build(64, 1'b0, 20);
    expect_frame(19, 1'b0, 3'b000, 20);
    send_pre();
    for (int i = 0; i < 20; i++) send(body[i], 1'b0, 1'b0);
    rst_b_n = 1'b0;
    #1;
    chk("b_reset_out", {od_b, ov_b, sof_b, eof_b, ec_b, hv_b}, 0);
    chk("b_reset_hdr", {da_b, sa_b, et_b}, 0);
    chk("b_reset_stats", {ok_b, fe_b, ce_b, le_b, pe_b}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_b_n = 1'b1;
    @(posedge clk);
    #1;
    drain();
    build(64, 1'b0, 21);
    expect_frame(64, 1'b1, 3'b000, 64);
    send_frame(0);
    drain();
    chk("b_frames_ok", ok_b, 1);
    chk("b_frames_err", fe_b, 0);
    build(40, 1'b0, 22);
    expect_frame(40, 1'b1, 3'b010, 40);
    send_frame(0);
    drain();
    chk("b_frames_err_short", fe_b, 1);
    chk("b_len_err_short", le_b, 1);
    chk("b_crc_err_short", ce_b, 0);
    chk("b_frames_ok_short", ok_b, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
